// File: rtl/array_allocator.sv
// Array-handle allocator: hands out handles (LIFO reuse of freed ones, then fresh ids),
// tracks per-array length, live count and high-water mark, and flags bad frees/updates.
//
// state | meaning
// INIT  | clearing sizes[] one entry per cycle, requests ignored, ready=0
// READY | servicing alloc / free / update requests
module array_allocator #(
   parameter int MemoryElementWidth = 12,
   parameter int NArrays = 2000,
   localparam int W = MemoryElementWidth,
   localparam int CW = $clog2(NArrays + 1)
) (
   input  logic          clock,
   input  logic          reset,
   output logic          ready,
   input  logic          alloc_req,
   output logic          alloc_ack,
   output logic          alloc_fail,
   output logic [W-1:0]  alloc_id,
   input  logic          free_req,
   input  logic [W-1:0]  free_id,
   output logic          free_ack,
   output logic          free_err,
   input  logic          upd_req,
   input  logic [W-1:0]  upd_id,
   input  logic [W-1:0]  upd_index,
   output logic          upd_err,
   input  logic [W-1:0]  qry_id,
   output logic [W-1:0]  qry_size,
   output logic [CW-1:0] in_use,
   output logic [CW-1:0] high_water
);

   localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam logic [W:0]    NA_W   = (W+1)'(NArrays);
   localparam logic [CW-1:0] NA_C   = CW'(NArrays);
   localparam logic [CW-1:0] LAST_C = CW'(NArrays - 1);

   typedef enum logic {INIT, READY} state_t;

   state_t              state;
   logic [CW-1:0]       init_cnt;
   logic [CW-1:0]       top;
   logic [NArrays-1:0]  bitmap;
   logic [W-1:0]        sizes [NArrays];
   logic [W-1:0]        stack [NArrays];

   logic                st_ready;
   logic [AW-1:0]       fidx, uidx, qidx, gidx;
   logic [CW-1:0]       tm1;
   logic                free_ok, free_bad, bypass, take, pop, fresh, afail, push, upd_ok;
   logic [W-1:0]        grant_id;
   logic [W:0]          upd_inc;
   logic [W-1:0]        upd_sat, upd_val;

   always_comb begin
      st_ready = (state == READY);
      fidx     = free_id[AW-1:0];
      uidx     = upd_id[AW-1:0];
      qidx     = qry_id[AW-1:0];
      tm1      = top - CW'(1);

      free_ok  = st_ready && free_req && ({1'b0, free_id} < NA_W) && bitmap[fidx];
      free_bad = st_ready && free_req && !free_ok;
      // a valid free in the same cycle as an alloc hands its id straight back out
      bypass   = alloc_req && free_ok;
      take     = st_ready && alloc_req && !free_ok;
      pop      = take && (top != '0);
      fresh    = take && (top == '0) && (high_water < NA_C);
      afail    = take && (top == '0) && !(high_water < NA_C);
      push     = free_ok && !alloc_req;

      grant_id = '0;
      if (bypass)
         grant_id = free_id;
      else if (pop)
         grant_id = stack[tm1[AW-1:0]];
      else if (fresh)
         grant_id = W'(high_water);
      gidx = grant_id[AW-1:0];

      upd_ok  = st_ready && upd_req && ({1'b0, upd_id} < NA_W) && bitmap[uidx];
      upd_inc = {1'b0, upd_index} + (W+1)'(1);
      upd_sat = upd_inc[W] ? {W{1'b1}} : upd_inc[W-1:0];
      upd_val = (upd_sat > sizes[uidx]) ? upd_sat : sizes[uidx];
   end

   // zeroing writes come last so free/alloc override a same-cycle update
   always_ff @(posedge clock) begin
      if (state == INIT) begin
         sizes[init_cnt[AW-1:0]] <= '0;
      end else begin
         if (upd_ok)
            sizes[uidx] <= upd_val;
         if (pop || fresh || bypass)
            sizes[gidx] <= '0;
         if (free_ok)
            sizes[fidx] <= '0;
      end
      if (push)
         stack[top[AW-1:0]] <= free_id;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= INIT;
         init_cnt   <= '0;
         top        <= '0;
         bitmap     <= '0;
         ready      <= 1'b0;
         alloc_ack  <= 1'b0;
         alloc_fail <= 1'b0;
         alloc_id   <= '0;
         free_ack   <= 1'b0;
         free_err   <= 1'b0;
         upd_err    <= 1'b0;
         qry_size   <= '0;
         in_use     <= '0;
         high_water <= '0;
      end else begin
         alloc_ack  <= 1'b0;
         alloc_fail <= 1'b0;
         free_ack   <= 1'b0;
         free_err   <= 1'b0;
         upd_err    <= 1'b0;
         alloc_id   <= grant_id;
         qry_size   <= (({1'b0, qry_id} < NA_W) && bitmap[qidx]) ? sizes[qidx] : '0;
         case (state)
            INIT: begin
               init_cnt <= init_cnt + CW'(1);
               if (init_cnt == LAST_C) begin
                  state <= READY;
                  ready <= 1'b1;
               end
            end
            READY: begin
               alloc_ack  <= alloc_req;
               alloc_fail <= afail;
               free_ack   <= free_req;
               free_err   <= free_bad;
               upd_err    <= upd_req && !upd_ok;
               if (pop || fresh) begin
                  bitmap[gidx] <= 1'b1;
                  in_use       <= in_use + CW'(1);
               end
               if (pop)
                  top <= tm1;
               if (fresh)
                  high_water <= high_water + CW'(1);
               if (push) begin
                  bitmap[fidx] <= 1'b0;
                  top          <= top + CW'(1);
                  in_use       <= in_use - CW'(1);
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_array_allocator.sv
// Bench for array_allocator: a 2000-handle and a 4-handle instance share stimulus;
// a per-instance reference model is compared against both every cycle.
module tb_array_allocator;
   localparam int W = 12;
   localparam int NA [2] = '{2000, 4};

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic alloc_req, free_req, upd_req;
   logic [W-1:0] free_id, upd_id, upd_index, qry_id;

   logic ready0, aack0, afail0, fack0, ferr0, uerr0;
   logic [W-1:0] aid0, qs0;
   logic [10:0] iu0, hw0;
   logic ready1, aack1, afail1, fack1, ferr1, uerr1;
   logic [W-1:0] aid1, qs1;
   logic [2:0] iu1, hw1;

   array_allocator #(.MemoryElementWidth(W), .NArrays(2000)) dut0 (
      .clock(clock), .reset(reset), .ready(ready0),
      .alloc_req(alloc_req), .alloc_ack(aack0), .alloc_fail(afail0), .alloc_id(aid0),
      .free_req(free_req), .free_id(free_id), .free_ack(fack0), .free_err(ferr0),
      .upd_req(upd_req), .upd_id(upd_id), .upd_index(upd_index), .upd_err(uerr0),
      .qry_id(qry_id), .qry_size(qs0), .in_use(iu0), .high_water(hw0));

   array_allocator #(.MemoryElementWidth(W), .NArrays(4)) dut1 (
      .clock(clock), .reset(reset), .ready(ready1),
      .alloc_req(alloc_req), .alloc_ack(aack1), .alloc_fail(afail1), .alloc_id(aid1),
      .free_req(free_req), .free_id(free_id), .free_ack(fack1), .free_err(ferr1),
      .upd_req(upd_req), .upd_id(upd_id), .upd_index(upd_index), .upd_err(uerr1),
      .qry_id(qry_id), .qry_size(qs1), .in_use(iu1), .high_water(hw1));

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int since_rst = 0;

   // reference model: allocated set, sizes, LIFO of freed ids, counters
   bit m_bm  [2][2000];
   int m_sz  [2][2000];
   int m_stk [2][2000];
   int m_sp [2], m_hw [2], m_inuse [2], m_cnt [2];
   bit m_rdy [2];
   int e_rdy [2], e_aack [2], e_afail [2], e_aid [2], e_fack [2], e_ferr [2], e_uerr [2], e_qs [2];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      for (int i = 0; i < 2000; i++) m_bm[k][i] = 1'b0;
      m_sp[k] = 0; m_hw[k] = 0; m_inuse[k] = 0; m_cnt[k] = 0; m_rdy[k] = 1'b0;
      e_rdy[k] = 0; e_aack[k] = 0; e_afail[k] = 0; e_aid[k] = 0;
      e_fack[k] = 0; e_ferr[k] = 0; e_uerr[k] = 0; e_qs[k] = 0;
   endtask

   task automatic model_step(input int k);
      int n, fid, uid, q, aid, nv;
      bit fok, uok, ok;
      n = NA[k]; fid = int'(free_id); uid = int'(upd_id); q = int'(qry_id);
      aid = 0;
      e_qs[k] = 0;
      if (q < n) if (m_bm[k][q]) e_qs[k] = m_sz[k][q];
      e_aack[k] = 0; e_afail[k] = 0; e_aid[k] = 0; e_fack[k] = 0; e_ferr[k] = 0; e_uerr[k] = 0;
      if (!m_rdy[k]) begin
         m_cnt[k]++;
         if (m_cnt[k] == n) m_rdy[k] = 1'b1;
      end else begin
         fok = 1'b0;
         if (free_req && fid < n) fok = m_bm[k][fid];
         uok = 1'b0;
         if (upd_req && uid < n) uok = m_bm[k][uid];
         e_fack[k] = int'(free_req);
         e_ferr[k] = int'(free_req && !fok);
         e_uerr[k] = int'(upd_req && !uok);
         if (uok) begin
            nv = int'(upd_index) + 1;
            if (nv > 4095) nv = 4095;
            if (nv > m_sz[k][uid]) m_sz[k][uid] = nv;
         end
         if (alloc_req) begin
            e_aack[k] = 1;
            ok = 1'b1;
            if (fok) aid = fid;
            else if (m_sp[k] > 0) begin
               m_sp[k]--;
               aid = m_stk[k][m_sp[k]];
            end else if (m_hw[k] < n) begin
               aid = m_hw[k];
               m_hw[k]++;
            end else ok = 1'b0;
            if (ok) begin
               e_aid[k] = aid;
               m_sz[k][aid] = 0;
               if (!fok) begin
                  m_bm[k][aid] = 1'b1;
                  m_inuse[k]++;
               end
            end else e_afail[k] = 1;
         end
         if (fok) begin
            m_sz[k][fid] = 0;
            if (!alloc_req) begin
               m_bm[k][fid] = 1'b0;
               m_stk[k][m_sp[k]] = fid;
               m_sp[k]++;
               m_inuse[k]--;
            end
         end
      end
      e_rdy[k] = int'(m_rdy[k]);
   endtask

   always @(posedge clock or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) model_reset(k);
         else model_step(k);
      end
   end

   always @(posedge clock) begin
      if (reset) since_rst <= 0;
      else since_rst <= since_rst + 1;
   end

   task automatic cmp_outs(input int k, input int rdy, input int aa, input int af, input int ai,
                           input int fa, input int fe, input int ue, input int qs,
                           input int iu, input int hw);
      chk($sformatf("ready[%0d]", k), rdy, e_rdy[k]);
      chk($sformatf("alloc_ack[%0d]", k), aa, e_aack[k]);
      chk($sformatf("alloc_fail[%0d]", k), af, e_afail[k]);
      chk($sformatf("alloc_id[%0d]", k), ai, e_aid[k]);
      chk($sformatf("free_ack[%0d]", k), fa, e_fack[k]);
      chk($sformatf("free_err[%0d]", k), fe, e_ferr[k]);
      chk($sformatf("upd_err[%0d]", k), ue, e_uerr[k]);
      chk($sformatf("qry_size[%0d]", k), qs, e_qs[k]);
      chk($sformatf("in_use[%0d]", k), iu, m_inuse[k]);
      chk($sformatf("high_water[%0d]", k), hw, m_hw[k]);
   endtask

   always @(negedge clock) begin
      cmp_outs(0, int'(ready0), int'(aack0), int'(afail0), int'(aid0), int'(fack0),
               int'(ferr0), int'(uerr0), int'(qs0), int'(iu0), int'(hw0));
      cmp_outs(1, int'(ready1), int'(aack1), int'(afail1), int'(aid1), int'(fack1),
               int'(ferr1), int'(uerr1), int'(qs1), int'(iu1), int'(hw1));
   end

   task automatic cyc(input logic a, input logic f, input int fid,
                      input logic u, input int uid, input int uix);
      alloc_req = a; free_req = f; free_id = W'(fid);
      upd_req = u; upd_id = W'(uid); upd_index = W'(uix);
      @(posedge clock);
      #1;
      alloc_req = 1'b0; free_req = 1'b0; upd_req = 1'b0;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 0, 1'b0, 0, 0);
   endtask

   task automatic wait_ready(input string nm);
      for (int i = 0; i < 3000; i++) begin
         if (ready0) break;
         @(posedge clock);
         #1;
      end
      chk({nm, " ready"}, int'(ready0), 1);
      chk({nm, " ready latency"}, since_rst, 2000);
   endtask

   initial begin
      alloc_req = 1'b0; free_req = 1'b0; upd_req = 1'b0;
      free_id = '0; upd_id = '0; upd_index = '0; qry_id = '0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset ready", int'(ready0), 0);
      chk("reset in_use", int'(iu0), 0);
      reset = 1'b0;

      // small pool exhausts while the big one is still clearing
      repeat (5) idle();
      chk("t5 small ready", int'(ready1), 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
         chk("t5 id", int'(aid1), i);
         chk("t5 main ignored", int'(aack0), 0);
      end
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
      chk("t5 fail", int'(afail1), 1);
      chk("t5 fail id", int'(aid1), 0);
      chk("t5 in_use", int'(iu1), 4);

      wait_ready("t1");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
         chk("t1 id", int'(aid0), i);
      end
      chk("t1 in_use", int'(iu0), 3);
      chk("t1 high_water", int'(hw0), 3);

      cyc(1'b0, 1'b1, 1, 1'b0, 0, 0);
      cyc(1'b0, 1'b1, 0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
      chk("t3 lifo first", int'(aid0), 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
      chk("t3 lifo second", int'(aid0), 1);
      chk("t3 high_water", int'(hw0), 3);

      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
         chk("t2 id", int'(aid0), 3);
         cyc(1'b0, 1'b1, 3, 1'b0, 0, 0);
      end
      chk("t2 high_water", int'(hw0), 4);
      chk("t2 in_use", int'(iu0), 3);

      cyc(1'b0, 1'b1, 1, 1'b0, 0, 0);
      chk("t4 free ok", int'(ferr0), 0);
      cyc(1'b0, 1'b1, 1, 1'b0, 0, 0);
      chk("t4 double free", int'(ferr0), 1);
      chk("t4 in_use", int'(iu0), 2);
      cyc(1'b0, 1'b1, 2500, 1'b0, 0, 0);
      chk("t4 range", int'(ferr0), 1);

      qry_id = W'(2);
      cyc(1'b0, 1'b0, 0, 1'b1, 2, 5);
      chk("t6 pre-write", int'(qs0), 0);
      idle();
      chk("t6 size", int'(qs0), 6);
      cyc(1'b0, 1'b0, 0, 1'b1, 2, 3);
      idle();
      chk("t6 max", int'(qs0), 6);
      cyc(1'b0, 1'b0, 0, 1'b1, 2, 4095);
      idle();
      chk("t6 saturate", int'(qs0), 4095);
      cyc(1'b0, 1'b0, 0, 1'b1, 3, 1);
      chk("t6 upd unalloc", int'(uerr0), 1);
      cyc(1'b0, 1'b1, 2, 1'b1, 2, 20);
      chk("t6 free+upd err", int'(uerr0), 0);
      chk("t6 free+upd ack", int'(fack0), 1);
      idle();
      chk("t6 freed size", int'(qs0), 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
      chk("t6 realloc", int'(aid0), 2);
      idle();
      chk("t6 realloc size", int'(qs0), 0);

      cyc(1'b1, 1'b1, 2, 1'b0, 0, 0);
      chk("t7 bypass id", int'(aid0), 2);
      chk("t7 bypass free err", int'(ferr0), 0);
      chk("t7 in_use", int'(iu0), 2);
      cyc(1'b1, 1'b1, 1, 1'b0, 0, 0);
      chk("t7 bad free", int'(ferr0), 1);
      chk("t7 alloc pops", int'(aid0), 1);
      chk("t7 in_use after", int'(iu0), 3);

      reset = 1'b1;
      #1;
      chk("t8 ready mid-READY", int'(ready0), 0);
      chk("t8 in_use", int'(iu0), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (500) idle();
      reset = 1'b1;
      #1;
      chk("t8 ready mid-INIT", int'(ready0), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      wait_ready("t8");
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
      chk("t8 first id", int'(aid0), 0);
      chk("t8 high_water", int'(hw0), 1);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
